qmul_sat_pipe: RTL and testbench
================================

Name: qmul_sat_pipe

Overview:
Pipelined, parametrised signed fixed-point multiplier with selectable rounding and saturation. Next generation of the small combinational Q-format saturating multiplier used in the IIR datapath. Adds generic width and fraction bits, three rounding modes, a 3-stage valid/ready pipeline with backpressure, and sticky and counted overflow status for the coefficient/section datapath of the configurable Chebyshev-II IIR.

Parameters:
W, 16, operand and result width (two's complement, Q(W-FRAC).FRAC); legal range 4..32.
FRAC, 14, fraction bits of operands and result; legal range 1..W-1.
CNT_W, 16, width of the saturating overflow event counter.

Ports:
clk  in  1  clock, rising-edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand pair valid.
in_ready  out  1  block can accept an operand pair this cycle.
a  in  W  signed multiplicand.
b  in  W  signed multiplier.
rnd_mode  in  2  0=truncate (floor), 1=round-half-up, 2=round-half-even, 3=reserved (treated as 0); sampled with operands.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
p  out  W  signed saturated result.
ovf  out  1  this result was saturated; qualified by out_valid.
ovf_sticky  out  1  set on any saturated result since the last clear.
ovf_clr  in  1  synchronous clear of ovf_sticky and ovf_cnt.
ovf_cnt  out  CNT_W  number of saturated results delivered, saturating at all-ones.

Behaviour:
- Reset (async assert, sync release): all stage valids=0, p=0, ovf=0, ovf_sticky=0, ovf_cnt=0; in_ready=1 once reset is released.
- Pipeline: S1 registers a, b, rnd_mode. S2 registers the full 2W-bit signed product and mode. S3 registers the rounded, saturated p and ovf. Latency 3 cycles from accepted input (in_valid&&in_ready) to out_valid. Throughput 1 per cycle.
- Stall: stall = out_valid && !out_ready. While stalled, all stages hold, in_ready=0, and no input is accepted. Bubbles (invalid stages) must not block: a stage advances whenever the stage after it is empty or advancing.
- Output data and ovf stay stable while out_valid && !out_ready.
- Arithmetic: prod = a*b as 2W-bit signed, Q.2FRAC. Rounded value r (2W+1 bits, no intermediate overflow):
  - truncate: r = prod >>> FRAC.
  - half-up: r = (prod + 2^(FRAC-1)) >>> FRAC.
  - half-even: r = (prod + 2^(FRAC-1) - 1 + bit FRAC of prod) >>> FRAC.
- Saturation: if r > 2^(W-1)-1, then p = 2^(W-1)-1 and ovf=1. If r < -2^(W-1), then p = -2^(W-1) and ovf=1. Otherwise p = r[W-1:0] and ovf=0.
- Status counts at the output handshake only (out_valid && out_ready && ovf): ovf_sticky is set and ovf_cnt increments, holding at 2^CNT_W-1. A stalled result is counted exactly once.
- ovf_clr in the same cycle as a counted event: the event wins, giving ovf_sticky=1 and ovf_cnt=1.
- Reset mid-operation discards all in-flight data. No output handshake occurs.

Decomposition:
- Package qmul_pkg: rnd_mode encodings (RND_TRUNC, RND_HALF_UP, RND_HALF_EVEN) and a width-generic saturation-limit function.
- One natural sub-module, qmul_round_sat: combinational round+saturate from 2W-bit product to W-bit result plus ovf. Instantiated in S3. Reusable by the adder/accumulator stages.

Test Plan:
- W=4, FRAC=2, mode 0: a=7, b=7 -> p=7, ovf=1 (product 49, >>>2 = 12). a=-8, b=-8 -> p=7, ovf=1. a=-8, b=7 -> p=-8, ovf=1. All appear 3 cycles after acceptance.
- W=4, FRAC=2, a=5, b=2 (2.5): mode0 -> 2, mode1 -> 3, mode2 -> 2. a=3, b=2 (1.5): modes -> 1, 2, 2. a=-3, b=2 (-1.5): modes -> -2, -1, -2. All with ovf=0.
- Backpressure: stream 6 inputs, hold out_ready=0 for 4 cycles after the first out_valid -> in_ready=0 and p held stable while stalled. All 6 results are delivered in order with none lost or duplicated.
- Counters: 3 saturating results, one of them held stalled for 2 cycles -> ovf_cnt=3, ovf_sticky=1. Pulse ovf_clr alone -> 0/0. Pulse ovf_clr together with a counted overflow -> ovf_cnt=1, ovf_sticky=1.
- CNT_W=2: 5 overflows -> ovf_cnt saturates at 3.
- Assert rst_n low with 3 results in flight -> out_valid=0, p=0, ovf=0 immediately (asynchronous). No stale output after release.

Source files
------------

// File: rtl/qmul_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qmul_pkg : rounding-mode encodings and saturation limits for qmul blocks
// Rev 1.0
// ---------------------------------------------------------------------------
package qmul_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC     = 2'd0,
    RND_HALF_UP   = 2'd1,
    RND_HALF_EVEN = 2'd2,
    RND_RSVD      = 2'd3
  } rnd_mode_e;

  // Largest (neg=0) or smallest (neg=1) two's-complement value of a w-bit word
  function automatic logic signed [63:0] sat_limit(input int w, input logic neg);
    logic signed [63:0] one;
    one = 64'sd1;
    if (neg) return -(one <<< (w - 1));
    else     return (one <<< (w - 1)) - 64'sd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qmul_round_sat.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qmul_round_sat : combinational rounding of a Q.2FRAC product to Q.FRAC,
//                  saturated to W bits with an overflow flag
// Rev 1.0
// ---------------------------------------------------------------------------
module qmul_round_sat
  import qmul_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 14
) (
  input  logic signed [2*W-1:0] prod,
  input  rnd_mode_e             mode,
  output logic signed [W-1:0]   p,
  output logic                  ovf
);

  localparam logic signed [2*W:0] c_max  = (2*W+1)'(sat_limit(W, 1'b0));
  localparam logic signed [2*W:0] c_min  = (2*W+1)'(sat_limit(W, 1'b1));
  localparam logic signed [2*W:0] c_half = (2*W+1)'(1) <<< (FRAC - 1);

  logic signed [2*W:0] w_ext;
  logic signed [2*W:0] w_bias;
  logic signed [2*W:0] w_r;

  always_comb begin
    w_ext  = {prod[2*W-1], prod};
    w_bias = '0;
    case (mode)
      RND_HALF_UP:   w_bias = c_half;
      // Ties go up only when the kept LSB is odd, landing on the even neighbour
      RND_HALF_EVEN: w_bias = c_half - (2*W+1)'(1) + {{(2*W){1'b0}}, prod[FRAC]};
      default:       w_bias = '0;
    endcase
    w_r = (w_ext + w_bias) >>> FRAC;

    p   = w_r[W-1:0];
    ovf = 1'b0;
    if (w_r > c_max) begin
      p   = {1'b0, {(W-1){1'b1}}};
      ovf = 1'b1;
    end else if (w_r < c_min) begin
      p   = {1'b1, {(W-1){1'b0}}};
      ovf = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/qmul_sat_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qmul_sat_pipe : 3-stage valid/ready signed Q-format multiplier with
//                 selectable rounding, saturation and overflow status
// Rev 1.0
// ---------------------------------------------------------------------------
module qmul_sat_pipe
  import qmul_pkg::*;
#(
  parameter int W     = 16,
  parameter int FRAC  = 14,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [1:0]       rnd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     p,
  output logic             ovf,
  output logic             ovf_sticky,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_cnt
);

  logic                  w_adv;
  logic                  w_evt;
  logic signed [2*W-1:0] w_prod;
  logic signed [W-1:0]   w_p;
  logic                  w_ovf;

  logic                  r_v1, r_v2, r_v3;
  logic signed [W-1:0]   r_a, r_b;
  rnd_mode_e             r_mode1, r_mode2;
  logic signed [2*W-1:0] r_prod;
  logic [W-1:0]          r_p;
  logic                  r_ovf;
  logic                  r_sticky;
  logic [CNT_W-1:0]      r_cnt;

  // Only a held result at the output can stall; empty stages never block
  assign w_adv    = !(r_v3 && !out_ready);
  assign in_ready = w_adv;
  assign w_prod   = (2*W)'(r_a) * (2*W)'(r_b);
  assign w_evt    = r_v3 && out_ready && r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_mode1 <= RND_TRUNC;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_a     <= a;
        r_b     <= b;
        r_mode1 <= rnd_mode_e'(rnd_mode);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2    <= 1'b0;
      r_prod  <= '0;
      r_mode2 <= RND_TRUNC;
    end else if (w_adv) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_prod  <= w_prod;
        r_mode2 <= r_mode1;
      end
    end
  end

  qmul_round_sat #(.W(W), .FRAC(FRAC)) u_round_sat (
    .prod (r_prod),
    .mode (r_mode2),
    .p    (w_p),
    .ovf  (w_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3  <= 1'b0;
      r_p   <= '0;
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_p   <= w_p;
        r_ovf <= w_ovf;
      end
    end
  end

  // A counted event beats a simultaneous clear, restarting the count at one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (w_evt) begin
      r_sticky <= 1'b1;
      if (ovf_clr)     r_cnt <= CNT_W'(1);
      else if (!(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
    end else if (ovf_clr) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end
  end

  assign out_valid  = r_v3;
  assign p          = r_p;
  assign ovf        = r_ovf;
  assign ovf_sticky = r_sticky;
  assign ovf_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_qmul_sat_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_qmul_sat_pipe : vector table plus scoreboard bench for qmul_sat_pipe
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_qmul_sat_pipe;

  localparam int W    = 4;
  localparam int FRAC = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         ovf_clr = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   rnd_mode = '0;

  logic         in_ready, out_valid, ovf, ovf_sticky;
  logic [W-1:0] p;
  logic [15:0]  ovf_cnt;
  logic         in_ready2, out_valid2, ovf2, ovf_sticky2;
  logic [W-1:0] p2;
  logic [1:0]   ovf_cnt2;

  qmul_sat_pipe #(.W(W), .FRAC(FRAC), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rnd_mode(rnd_mode), .out_valid(out_valid),
    .out_ready(out_ready), .p(p), .ovf(ovf), .ovf_sticky(ovf_sticky),
    .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt)
  );

  qmul_sat_pipe #(.W(W), .FRAC(FRAC), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .rnd_mode(rnd_mode), .out_valid(out_valid2),
    .out_ready(out_ready), .p(p2), .ovf(ovf2), .ovf_sticky(ovf_sticky2),
    .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt2)
  );

  always #5 clk = ~clk;

  typedef struct { int p; int ovf; } exp_t;
  typedef struct { int a; int b; int mode; int p; int ovf; } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_fail = 0;
  int   n_pops = 0;
  int   cyc = 0;
  int   last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int ai, input int bi, input int m, input int ep, input int eo);
    vec_t v;
    v.a = ai; v.b = bi; v.mode = m; v.p = ep; v.ovf = eo;
    return v;
  endfunction

  // Reference: exact floor plus remainder-based rounding decision
  function automatic void model(input int ai, input int bi, input int m, output int ep, output int eo);
    int prod, fl, rem, half, r, lo, hi;
    prod = ai * bi;
    fl   = prod >>> FRAC;
    rem  = prod - fl * (1 << FRAC);
    half = 1 << (FRAC - 1);
    r    = fl;
    if (m == 1 && rem >= half) r = fl + 1;
    if (m == 2 && (rem > half || (rem == half && (fl % 2) != 0))) r = fl + 1;
    hi = (1 << (W - 1)) - 1;
    lo = -(1 << (W - 1));
    eo = 0;
    ep = r;
    if (r > hi) begin ep = hi; eo = 1; end
    if (r < lo) begin ep = lo; eo = 1; end
  endfunction

  task automatic send(input int ai, input int bi, input int m, input int ep, input int eo);
    bit   acc;
    exp_t e;
    in_valid = 1'b1;
    a        = W'(ai);
    b        = W'(bi);
    rnd_mode = 2'(m);
    acc      = 1'b0;
    for (int g = 0; g < 200 && !acc; g++) begin
      @(negedge clk);
      if (in_ready) begin
        acc      = 1'b1;
        last_acc = cyc;
        e.p = ep; e.ovf = eo;
        sb.push_back(e);
      end
    end
    if (!acc) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_m(input int ai, input int bi, input int m);
    int ep, eo;
    model(ai, bi, m, ep, eo);
    send(ai, bi, m, ep, eo);
  endtask

  task automatic wait_ov();
    bit seen;
    seen = 1'b0;
    for (int g = 0; g < 50 && !seen; g++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) check("out_valid_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int g = 0; g < 100 && sb.size() != 0; g++) @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_clr();
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_output", 1, 0);
      else begin
        mon_e = sb.pop_front();
        n_pops++;
        check("p", int'($signed(p)), mon_e.p);
        check("ovf", int'(ovf), mon_e.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   snap;
    int   pops0;

    tbl.push_back(mk( 7,  7, 0,  7, 1));
    tbl.push_back(mk(-8, -8, 0,  7, 1));
    tbl.push_back(mk(-8,  7, 0, -8, 1));
    tbl.push_back(mk( 5,  2, 0,  2, 0));
    tbl.push_back(mk( 5,  2, 1,  3, 0));
    tbl.push_back(mk( 5,  2, 2,  2, 0));
    tbl.push_back(mk( 3,  2, 0,  1, 0));
    tbl.push_back(mk( 3,  2, 1,  2, 0));
    tbl.push_back(mk( 3,  2, 2,  2, 0));
    tbl.push_back(mk(-3,  2, 0, -2, 0));
    tbl.push_back(mk(-3,  2, 1, -1, 0));
    tbl.push_back(mk(-3,  2, 2, -2, 0));
    tbl.push_back(mk( 5,  2, 3,  2, 0));
    tbl.push_back(mk(-1,  1, 0, -1, 0));
    tbl.push_back(mk(-1,  1, 1,  0, 0));
    tbl.push_back(mk(-1,  1, 2,  0, 0));
    tbl.push_back(mk( 7,  7, 1,  7, 1));
    tbl.push_back(mk(-8,  7, 1, -8, 1));

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_p", int'(p), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_sticky", int'(ovf_sticky), 0);
    check("rst_cnt", int'(ovf_cnt), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", int'(in_ready), 1);

    // Latency of a single isolated operation
    send(5, 2, 1, 3, 0);
    wait_ov();
    check("latency", cyc - last_acc, 3);
    drain();

    // Vector table, back to back
    foreach (tbl[i]) send(tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].p, tbl[i].ovf);
    drain();

    // Backpressure: 6-deep stream with a stall at the output
    pops0 = n_pops;
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++)
          send_m(int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                 int'($urandom_range(0, 3)));
      end
      begin
        wait_ov();
        snap = int'(p);
        repeat (4) begin
          @(negedge clk);
          check("stall_in_ready", int'(in_ready), 0);
          check("stall_p_hold", int'(p), snap);
          check("stall_out_valid", int'(out_valid), 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("stream_count", n_pops - pops0, 6);

    // Counters: three overflows, first held stalled
    pulse_clr();
    check("clr_cnt", int'(ovf_cnt), 0);
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 3; k++) send(7, 7, 0, 7, 1);
      end
      begin
        wait_ov();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("cnt_after3", int'(ovf_cnt), 3);
    check("sticky_after3", int'(ovf_sticky), 1);
    check("cnt2_after3", int'(ovf_cnt2), 3);

    pulse_clr();
    @(negedge clk);
    check("clr_only_cnt", int'(ovf_cnt), 0);
    check("clr_only_sticky", int'(ovf_sticky), 0);
    @(posedge clk); #1;

    // Clear coinciding with a counted overflow
    out_ready = 1'b0;
    send(-8, -8, 0, 7, 1);
    wait_ov();
    @(posedge clk); #1;
    out_ready = 1'b1;
    ovf_clr   = 1'b1;
    @(posedge clk); #1;
    ovf_clr   = 1'b0;
    check("clr_evt_cnt", int'(ovf_cnt), 1);
    check("clr_evt_sticky", int'(ovf_sticky), 1);
    drain();

    // Narrow counter saturates
    pulse_clr();
    for (int k = 0; k < 5; k++) send(-8, 7, 0, -8, 1);
    drain();
    check("cnt2_sat", int'(ovf_cnt2), 3);
    check("cnt_5", int'(ovf_cnt), 5);

    // Asynchronous reset with three results in flight
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send_m(7 - k, 3, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_p", int'(p), 0);
    check("arst_ovf", int'(ovf), 0);
    check("arst_sticky", int'(ovf_sticky), 0);
    sb.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("no_stale_out", int'(out_valid), 0);
    end
    check("post_rst_in_ready", int'(in_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
